// File: rtl/spi_arbiter.sv
// Two-requester arbiter in front of a single SPI engine: chip selects, setup/idle gaps, start/busy handshake, held-CS bursts.
// Optional HOLD timeout is compiled in with `define SPI_ARB_TIMEOUT_EN.
module spi_arbiter #(
  parameter int unsigned CS_SETUP     = 2,
  parameter int unsigned CS_IDLE      = 2,
  parameter int unsigned HOLD_TIMEOUT = 255
) (
  input  logic        raw_clk,
  input  logic        reset,
  input  logic        req_0,
  input  logic        req_1,
  input  logic        hold_0,
  input  logic        hold_1,
  input  logic        width_16_0,
  input  logic        width_16_1,
  input  logic [15:0] data_tx_0,
  input  logic [15:0] data_tx_1,
  output logic        grant_0,
  output logic        grant_1,
  output logic        done_0,
  output logic        done_1,
  output logic [7:0]  data_rx,
  output logic        cs_0,
  output logic        cs_1,
  output logic        spi_start,
  output logic        spi_width_16,
  output logic [15:0] spi_data_tx,
  input  logic        spi_busy,
  input  logic [7:0]  spi_data_rx
);

  if (CS_SETUP < 1 || CS_SETUP > 15 || CS_IDLE < 1 || CS_IDLE > 15 ||
      HOLD_TIMEOUT < 1 || HOLD_TIMEOUT > 255) begin : g_param_check
    $error("spi_arbiter: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_START, S_WAIT_BUSY, S_WAIT_DONE, S_DONE, S_HOLD, S_RELEASE
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  grant_q, grant_d;
  logic [1:0]  done_q, done_d;
  logic [7:0]  data_rx_q, data_rx_d;
  logic        start_q, start_d;
  logic        width_q, width_d;
  logic [15:0] tx_q, tx_d;
  logic        last_q, last_d;
`ifdef SPI_ARB_TIMEOUT_EN
  logic [7:0]  to_cnt_q, to_cnt_d;
`endif

  logic        own_req, own_hold, own_width, pick;
  logic [15:0] own_tx;

  assign own_req   = grant_q[1] ? req_1      : req_0;
  assign own_hold  = grant_q[1] ? hold_1     : hold_0;
  assign own_width = grant_q[1] ? width_16_1 : width_16_0;
  assign own_tx    = grant_q[1] ? data_tx_1  : data_tx_0;
  // On a tie the requester not served last wins; otherwise whoever is asking.
  assign pick      = (req_0 && req_1) ? ~last_q : req_1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    grant_d   = grant_q;
    done_d    = '0;
    data_rx_d = data_rx_q;
    start_d   = 1'b0;
    width_d   = width_q;
    tx_d      = tx_q;
    last_d    = last_q;
`ifdef SPI_ARB_TIMEOUT_EN
    to_cnt_d  = to_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (!spi_busy && (req_0 || req_1)) begin
          grant_d = pick ? 2'b10 : 2'b01;
          width_d = pick ? width_16_1 : width_16_0;
          tx_d    = pick ? data_tx_1 : data_tx_0;
          cnt_d   = '0;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt_q == 4'(CS_SETUP - 1)) begin
          start_d = 1'b1;
          state_d = S_START;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_START:     state_d = S_WAIT_BUSY;
      S_WAIT_BUSY: if (spi_busy) state_d = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (!spi_busy) begin
          data_rx_d = spi_data_rx;
          done_d    = grant_q;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        last_d = grant_q[1];
        if (own_hold) begin
`ifdef SPI_ARB_TIMEOUT_EN
          to_cnt_d = '0;
`endif
          state_d = S_HOLD;
        end else begin
          grant_d = '0;
          cnt_d   = '0;
          state_d = S_RELEASE;
        end
      end
      S_HOLD: begin
        if (own_req) begin
          width_d = own_width;
          tx_d    = own_tx;
          start_d = 1'b1;
`ifdef SPI_ARB_TIMEOUT_EN
          to_cnt_d = '0;
`endif
          state_d = S_START;
        end else if (!own_hold) begin
          grant_d = '0;
          cnt_d   = '0;
          state_d = S_RELEASE;
        end
`ifdef SPI_ARB_TIMEOUT_EN
        else if (to_cnt_q == 8'(HOLD_TIMEOUT - 1)) begin
          grant_d = '0;
          cnt_d   = '0;
          state_d = S_RELEASE;
        end else begin
          to_cnt_d = to_cnt_q + 8'd1;
        end
`endif
      end
      S_RELEASE: begin
        if (cnt_q == 4'(CS_IDLE - 1)) state_d = S_IDLE;
        else                          cnt_d   = cnt_q + 4'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge raw_clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      grant_q   <= '0;
      done_q    <= '0;
      data_rx_q <= '0;
      start_q   <= 1'b0;
      width_q   <= 1'b0;
      tx_q      <= '0;
      last_q    <= 1'b1;
`ifdef SPI_ARB_TIMEOUT_EN
      to_cnt_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      data_rx_q <= data_rx_d;
      start_q   <= start_d;
      width_q   <= width_d;
      tx_q      <= tx_d;
      last_q    <= last_d;
`ifdef SPI_ARB_TIMEOUT_EN
      to_cnt_q  <= to_cnt_d;
`endif
    end
  end

  // Chip selects follow the one-hot grant, so both can never be low together.
  assign grant_0      = grant_q[0];
  assign grant_1      = grant_q[1];
  assign cs_0         = ~grant_q[0];
  assign cs_1         = ~grant_q[1];
  assign done_0       = done_q[0];
  assign done_1       = done_q[1];
  assign data_rx      = data_rx_q;
  assign spi_start    = start_q;
  assign spi_width_16 = width_q;
  assign spi_data_tx  = tx_q;

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed bench for spi_arbiter with a small behavioural SPI engine (8 or 16 busy cycles per frame, no reset).
module tb_spi_arbiter;

  localparam int unsigned CS_SETUP = 2;
  localparam int unsigned CS_IDLE  = 2;
  localparam int unsigned HOLD_TO  = 10;

  logic        raw_clk = 1'b0;
  logic        reset   = 1'b1;
  logic        req_0 = 1'b0, req_1 = 1'b0, hold_0 = 1'b0, hold_1 = 1'b0;
  logic        width_16_0 = 1'b0, width_16_1 = 1'b0;
  logic [15:0] data_tx_0 = '0, data_tx_1 = '0;
  logic        grant_0, grant_1, done_0, done_1, cs_0, cs_1;
  logic [7:0]  data_rx;
  logic        spi_start, spi_width_16, spi_busy;
  logic [15:0] spi_data_tx;
  logic [7:0]  spi_data_rx;

  int tests = 0;
  int fails = 0;
  int both_low = 0;

  always #5 raw_clk = ~raw_clk;

  spi_arbiter #(.CS_SETUP(CS_SETUP), .CS_IDLE(CS_IDLE), .HOLD_TIMEOUT(HOLD_TO)) dut (
    .raw_clk(raw_clk), .reset(reset),
    .req_0(req_0), .req_1(req_1), .hold_0(hold_0), .hold_1(hold_1),
    .width_16_0(width_16_0), .width_16_1(width_16_1),
    .data_tx_0(data_tx_0), .data_tx_1(data_tx_1),
    .grant_0(grant_0), .grant_1(grant_1), .done_0(done_0), .done_1(done_1),
    .data_rx(data_rx), .cs_0(cs_0), .cs_1(cs_1),
    .spi_start(spi_start), .spi_width_16(spi_width_16), .spi_data_tx(spi_data_tx),
    .spi_busy(spi_busy), .spi_data_rx(spi_data_rx)
  );

  // Engine model: latches the frame on start, busy for 8/16 cycles, then presents eng_rx.
  logic        eng_busy = 1'b0;
  logic [4:0]  eng_cnt  = '0;
  logic [15:0] eng_tx   = '0;
  logic        eng_w16  = 1'b0;
  logic [7:0]  eng_rx   = '0;
  logic [7:0]  eng_out  = '0;

  always @(posedge raw_clk) begin
    if (eng_busy) begin
      if (eng_cnt == 5'd1) begin
        eng_busy <= 1'b0;
        eng_out  <= eng_rx;
      end
      eng_cnt <= eng_cnt - 5'd1;
    end else if (spi_start) begin
      eng_busy <= 1'b1;
      eng_cnt  <= spi_width_16 ? 5'd16 : 5'd8;
      eng_tx   <= spi_data_tx;
      eng_w16  <= spi_width_16;
    end
  end
  assign spi_busy    = eng_busy;
  assign spi_data_rx = eng_out;

  always @(negedge raw_clk) if (!cs_0 && !cs_1) both_low++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge raw_clk);
    #1;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      cyc();
      if (done_0 || done_1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    bit ok;
    bit found;
    int cnt, gap, min_gap, k, n, g0, cs1_high, cnt_gap, t, fell, gnt;
    bit started, measuring;
    logic [3:0] order;

    // Reset values
    repeat (2) cyc();
    check("rst_grant", 32'({grant_1, grant_0}), 32'h0);
    check("rst_done",  32'({done_1, done_0}), 32'h0);
    check("rst_cs",    32'({cs_1, cs_0}), 32'h3);
    check("rst_rx",    32'(data_rx), 32'h0);
    check("rst_start", 32'({spi_start, spi_width_16}), 32'h0);
    check("rst_tx",    32'(spi_data_tx), 32'h0);
    reset = 1'b0;
    cyc();

    // Single 8-bit transfer from requester 0
    data_tx_0 = 16'h00A5; width_16_0 = 1'b0; eng_rx = 8'h3C; req_0 = 1'b1;
    found = 1'b0; cnt = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      cyc();
      if (spi_start) found = 1'b1;
      else if (!cs_0) cnt++;
    end
    check("t1_start_seen", 32'(found), 32'h1);
    check("t1_setup_cycles", 32'(cnt), 32'(CS_SETUP));
    wait_done(ok);
    check("t1_done_seen", 32'(ok), 32'h1);
    check("t1_done_owner", 32'({done_1, done_0}), 32'h1);
    check("t1_data_rx", 32'(data_rx), 32'h3C);
    check("t1_mosi", 32'({eng_w16, eng_tx}), 32'h000A5);
    req_0 = 1'b0;
    cyc();
    check("t1_after", 32'({done_0, cs_0}), 32'h1);
    repeat (4) cyc();

    // Round robin with both requesting; reset first so requester 0 wins the first tie
    reset = 1'b1; cyc(); reset = 1'b0; cyc();
    data_tx_0 = 16'h0011; data_tx_1 = 16'h0022; eng_rx = 8'h5A;
    req_0 = 1'b1; req_1 = 1'b1;
    started = 1'b0; gap = 0; min_gap = 99; k = 0; order = '0;
    for (int i = 0; i < 400 && k < 4; i++) begin
      cyc();
      if (cs_0 && cs_1) gap++;
      else begin
        if (started && gap != 0 && gap < min_gap) min_gap = gap;
        started = 1'b1;
        gap = 0;
      end
      if (done_0 || done_1) begin
        order[k] = done_1;
        k++;
        if (k == 4) begin req_0 = 1'b0; req_1 = 1'b0; end
      end
    end
    check("t2_count", 32'(k), 32'h4);
    check("t2_order", 32'(order), 32'hA);
    check("t2_min_gap", 32'(min_gap), 32'(CS_IDLE + 1));
    check("t2_data_rx", 32'(data_rx), 32'h5A);
    repeat (5) cyc();

    // Held 16-bit burst on requester 1 while requester 0 waits
    width_16_1 = 1'b1; data_tx_1 = 16'hBEEF; hold_1 = 1'b1; req_1 = 1'b1; eng_rx = 8'hC3;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      cyc();
      if (grant_1) found = 1'b1;
    end
    check("t3_grant1", 32'(found), 32'h1);
    req_0 = 1'b1; data_tx_0 = 16'h0077; width_16_0 = 1'b0;
    n = 0; cs1_high = 0; g0 = 0; cnt_gap = 0; measuring = 1'b0;
    for (int i = 0; i < 300 && n < 3; i++) begin
      cyc();
      if (cs_1) cs1_high++;
      if (grant_0) g0++;
      if (done_1) begin
        n++;
        if (n == 1) begin data_tx_1 = 16'hCAFE; measuring = 1'b1; cnt_gap = 0; end
        if (n == 2) data_tx_1 = 16'hF00D;
        if (n == 3) begin hold_1 = 1'b0; req_1 = 1'b0; end
      end else if (measuring) begin
        cnt_gap++;
        if (spi_start) measuring = 1'b0;
      end
    end
    check("t3_transfers", 32'(n), 32'h3);
    check("t3_cs1_high", 32'(cs1_high), 32'h0);
    check("t3_grant0_early", 32'(g0), 32'h0);
    check("t3_burst_gap", 32'(cnt_gap), 32'h2);
    check("t3_last_tx", 32'({eng_w16, eng_tx}), 32'h1F00D);
    check("t3_data_rx", 32'(data_rx), 32'hC3);
    cyc();
    check("t3_release", 32'({cs_1, grant_1}), 32'h2);
    t = 1; found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cyc();
      t++;
      if (grant_0) found = 1'b1;
    end
    check("t3_to_grant0", 32'(t), 32'h4);
    wait_done(ok);
    check("t3_done0", 32'({ok, done_1, done_0}), 32'h5);
    check("t3_tx0", 32'({eng_w16, eng_tx}), 32'h00077);
    req_0 = 1'b0;
    repeat (5) cyc();

    // Owner holds with no further request
    data_tx_0 = 16'h0042; eng_rx = 8'h11; hold_0 = 1'b1; req_0 = 1'b1;
    wait_done(ok);
    check("t5_done", 32'({ok, done_0}), 32'h3);
    req_0 = 1'b0;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (cs_0) break;
      cnt++;
    end
`ifdef SPI_ARB_TIMEOUT_EN
    check("t5_timeout", 32'(cnt), 32'(HOLD_TO));
`else
    check("t5_hold", 32'(cnt), 32'd40);
`endif
    hold_0 = 1'b0;
    cyc();
    check("t5_release", 32'(cs_0), 32'h1);
    repeat (4) cyc();

    // Reset while the arbiter waits for the engine to finish
    eng_rx = 8'h99; data_tx_0 = 16'h0055; req_0 = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cyc();
      if (spi_busy) found = 1'b1;
    end
    check("t4_busy_seen", 32'(found), 32'h1);
    repeat (2) cyc();
    reset = 1'b1;
    #1;
    check("t4_async", 32'({grant_0, cs_0, cs_1}), 32'h3);
    check("t4_async_rx", 32'(data_rx), 32'h0);
    cyc();
    reset = 1'b0;
    fell = -1; gnt = -1;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (!spi_busy && fell < 0) fell = i;
      if (grant_0) begin gnt = i; break; end
    end
    check("t4_busy_fell", 32'(fell >= 0), 32'h1);
    check("t4_grant_after_busy", 32'(gnt - fell), 32'h1);
    wait_done(ok);
    check("t4_done_rx", 32'({ok, data_rx}), 32'h199);
    req_0 = 1'b0;
    repeat (4) cyc();

    check("no_both_cs_low", 32'(both_low), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
